run_detect_fsm: RTL

- Parametrised detector for runs of consecutive 1s on a single-bit input, stepped by a push-button `next`.
- One bit is sampled per rising edge of `next`. `next` is edge-detected internally, so one press equals one step.
- Flags when the run length reaches TARGET. Output is Moore or Mealy (selectable), and restart is overlapping or non-overlapping (selectable).
- Exposes the current run length and a running hit counter; sits between board buttons/switches and the LED/7-seg display logic.

---
 rtl/run_detect_pkg.sv | 12 +
 rtl/run_detect_fsm_edge_pulse.sv | 25 ++
 rtl/run_detect_fsm.sv | 117 +++++++++++
 3 files changed

// File: rtl/run_detect_pkg.sv
// Shared state encodings for the button-stepped run detector.
package run_detect_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HIT   = 2'd2
  } state_t;

endpackage

// File: rtl/run_detect_fsm_edge_pulse.sv
// Rising-edge detector for a debounced button level; one pulse per press.
module edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_r1;
  logic level_r2;

  // Preset to 1 so a button held through reset release is not seen as a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_r1 <= 1'b1;
      level_r2 <= 1'b1;
    end else begin
      level_r1 <= level;
      level_r2 <= level_r1;
    end
  end

  assign pulse = level_r1 & ~level_r2;

endmodule

// File: rtl/run_detect_fsm.sv
// Detects runs of TARGET consecutive 1s on `in`, sampled once per `next` press.
//
// state | meaning
// IDLE  | run_len = 0
// COUNT | 0 < run_len < TARGET
// HIT   | run_len = TARGET
module run_detect_fsm
  import run_detect_pkg::*;
#(
  parameter int TARGET  = 4,
  parameter int CNT_W   = 3,
  parameter int MEALY   = 0,
  parameter int OVERLAP = 1,
  parameter int HIT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               next,
  input  logic               in,
  output logic               out,
  output logic               step,
  output logic [CNT_W-1:0]   run_len,
  output logic [STATE_W-1:0] state_display,
  output logic [HIT_W-1:0]   hit_count
);

  localparam logic [CNT_W-1:0] TGT = CNT_W'(TARGET);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  if (TARGET < 1 || TARGET > (2 ** CNT_W) - 1) begin : g_bad_target
    $error("run_detect_fsm: TARGET must lie in 1 .. 2**CNT_W-1");
  end

  logic             step_i;
  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] run_len_q;
  logic [CNT_W-1:0] run_len_nx;
  logic [HIT_W-1:0] hit_count_q;
  logic             hit_ev;
  logic             out_q;

  edge_pulse u_edge (
    .clk   (clk),
    .reset (reset),
    .level (next),
    .pulse (step_i)
  );

  // Next state as if a step were taken now; applied only on step edges.
  always_comb begin
    state_nx   = state;
    run_len_nx = run_len_q;
    hit_ev     = 1'b0;
    if (!in) begin
      state_nx   = IDLE;
      run_len_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          run_len_nx = ONE;
          state_nx   = (TARGET == 1) ? HIT : COUNT;
          hit_ev     = (TARGET == 1);
        end
        COUNT: begin
          run_len_nx = run_len_q + ONE;
          if (run_len_q + ONE == TGT) begin
            state_nx = HIT;
            hit_ev   = 1'b1;
          end
        end
        HIT: begin
          if (OVERLAP != 0) begin
            run_len_nx = TGT;
            state_nx   = HIT;
            hit_ev     = 1'b1;
          end else begin
            run_len_nx = ONE;
            state_nx   = (TARGET == 1) ? HIT : COUNT;
            hit_ev     = (TARGET == 1);
          end
        end
        default: begin
          state_nx   = IDLE;
          run_len_nx = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      run_len_q   <= '0;
      hit_count_q <= '0;
      out_q       <= 1'b0;
    end else if (!(state inside {IDLE, COUNT, HIT})) begin
      state     <= IDLE;
      run_len_q <= '0;
      out_q     <= 1'b0;
    end else if (step_i) begin
      state     <= state_nx;
      run_len_q <= run_len_nx;
      out_q     <= (state_nx == HIT);
      if (hit_ev) begin
        hit_count_q <= hit_count_q + HIT_W'(1);
      end
    end
  end

  assign out           = (MEALY != 0) ? (step_i & in & hit_ev) : out_q;
  assign step          = step_i;
  assign run_len       = run_len_q;
  assign state_display = state;
  assign hit_count     = hit_count_q;

endmodule
